// File: rtl/cpu_run_ctrl.sv
// Run controller for the multi-core CPU build: sequences per-core reset release, counts RUN cycles,
// and ends the run on all-core halt or budget expiry. Define RUN_CTRL_STAGGER_EN for one-per-cycle core release.
module cpu_run_ctrl #(
  parameter int NUM_CORES  = 1,
  parameter int RST_HOLD   = 2,
  parameter int RUN_CYCLES = 200,
  parameter int CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_CORES-1:0] halted,
  output logic [NUM_CORES-1:0] core_rst_n,
  output logic                 running,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [2:0]           dbg_state
);

  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam logic [CNT_W-1:0] BUDGET_LAST = CNT_W'(RUN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RESET   = 3'd1,
    S_RUN     = 3'd2,
`ifdef RUN_CTRL_STAGGER_EN
    S_DONE    = 3'd3,
    S_RELEASE = 3'd4
`else
    S_DONE    = 3'd3
`endif
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [HOLD_W-1:0]      r_hold, w_hold_nxt;
  logic [NUM_CORES-1:0]   r_core_rst_n, w_rst_n_nxt;
  logic                   r_running, r_done;
  logic                   r_timeout, w_timeout_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
`ifdef RUN_CTRL_STAGGER_EN
  localparam int IDX_W = $clog2(NUM_CORES + 1);
  logic [IDX_W-1:0]       r_idx, w_idx_nxt;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_hold       <= '0;
      r_core_rst_n <= '0;
      r_running    <= 1'b0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      r_cnt        <= '0;
`ifdef RUN_CTRL_STAGGER_EN
      r_idx        <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_hold       <= w_hold_nxt;
      r_core_rst_n <= w_rst_n_nxt;
      r_running    <= (w_state_nxt == S_RUN);
      r_done       <= (w_state_nxt == S_DONE);
      r_timeout    <= w_timeout_nxt;
      r_cnt        <= w_cnt_nxt;
`ifdef RUN_CTRL_STAGGER_EN
      r_idx        <= w_idx_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_hold_nxt    = r_hold;
    w_rst_n_nxt   = r_core_rst_n;
    w_timeout_nxt = r_timeout;
    w_cnt_nxt     = r_cnt;
`ifdef RUN_CTRL_STAGGER_EN
    w_idx_nxt     = r_idx;
`endif
    case (r_state)
      S_IDLE: begin
        w_rst_n_nxt = '0;
        if (start) begin
          w_state_nxt = S_RESET;
          w_hold_nxt  = HOLD_W'(RST_HOLD);
        end
      end
      // Hold counter runs RST_HOLD..0, so release happens on the edge after the last held edge.
      S_RESET: begin
        w_rst_n_nxt = '0;
        if (r_hold == '0) begin
`ifdef RUN_CTRL_STAGGER_EN
          w_state_nxt = S_RELEASE;
          w_rst_n_nxt = NUM_CORES'(1);
          w_idx_nxt   = IDX_W'(1);
`else
          w_state_nxt = S_RUN;
          w_rst_n_nxt = '1;
          w_cnt_nxt   = '0;
`endif
        end else begin
          w_hold_nxt = r_hold - HOLD_W'(1);
        end
      end
`ifdef RUN_CTRL_STAGGER_EN
      S_RELEASE: begin
        if (r_idx == IDX_W'(NUM_CORES)) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_rst_n_nxt = r_core_rst_n | (NUM_CORES'(1) << r_idx);
          w_idx_nxt   = r_idx + IDX_W'(1);
        end
      end
`endif
      // Halt takes priority over budget expiry; the count saturates rather than wraps.
      S_RUN: begin
        if (r_cnt != '1) w_cnt_nxt = r_cnt + CNT_W'(1);
        if (&halted) begin
          w_state_nxt   = S_DONE;
          w_rst_n_nxt   = '0;
          w_timeout_nxt = 1'b0;
        end else if ((RUN_CYCLES != 0) && (r_cnt == BUDGET_LAST)) begin
          w_state_nxt   = S_DONE;
          w_rst_n_nxt   = '0;
          w_timeout_nxt = 1'b1;
        end
      end
      S_DONE: begin
        w_rst_n_nxt = '0;
        if (start) begin
          w_state_nxt   = S_RESET;
          w_hold_nxt    = HOLD_W'(RST_HOLD);
          w_timeout_nxt = 1'b0;
          w_cnt_nxt     = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_rst_n_nxt = '0;
      end
    endcase
  end

  assign core_rst_n  = r_core_rst_n;
  assign running     = r_running;
  assign done        = r_done;
  assign timeout     = r_timeout;
  assign cycle_count = r_cnt;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: a 1-core/200-cycle instance and a 4-core/50-cycle instance.
module tb_cpu_run_ctrl;

`ifdef RUN_CTRL_STAGGER_EN
  localparam int RUN_LAT_A = 4;
  localparam int RUN_LAT_B = 7;
`else
  localparam int RUN_LAT_A = 3;
  localparam int RUN_LAT_B = 3;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        a_start, a_running, a_done, a_timeout;
  logic [0:0]  a_halted, a_core_rst_n;
  logic [31:0] a_cnt;
  logic [2:0]  a_state;

  logic        b_start, b_running, b_done, b_timeout;
  logic [3:0]  b_halted, b_core_rst_n;
  logic [7:0]  b_cnt;
  logic [2:0]  b_state;

  cpu_run_ctrl #(.NUM_CORES(1), .RST_HOLD(2), .RUN_CYCLES(200), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .halted(a_halted), .core_rst_n(a_core_rst_n),
    .running(a_running), .done(a_done), .timeout(a_timeout), .cycle_count(a_cnt), .dbg_state(a_state)
  );

  cpu_run_ctrl #(.NUM_CORES(4), .RST_HOLD(2), .RUN_CYCLES(50), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .halted(b_halted), .core_rst_n(b_core_rst_n),
    .running(b_running), .done(b_done), .timeout(b_timeout), .cycle_count(b_cnt), .dbg_state(b_state)
  );

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic       start;
    logic [3:0] halted;
    logic [3:0] exp_rst_n;
    logic       exp_run;
    logic       exp_done;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input logic s, input logic [3:0] h, input logic [3:0] r,
                              input logic run, input logic d, input logic [7:0] c);
    vec_t v;
    v.start = s; v.halted = h; v.exp_rst_n = r; v.exp_run = run; v.exp_done = d; v.exp_cnt = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int n, m;
    rst = 1'b1; a_start = 1'b0; a_halted = '0; b_start = 1'b0; b_halted = '0;

    // startup vectors for dut_b: inputs applied before edge Ei, outputs checked after it
    vecs[0] = mk(1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 8'd0);
    vecs[1] = mk(1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 8'd0);
    vecs[2] = mk(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 8'd0);
`ifdef RUN_CTRL_STAGGER_EN
    vecs[3] = mk(1'b0, 4'b0000, 4'b0001, 1'b0, 1'b0, 8'd0);
    vecs[4] = mk(1'b0, 4'b0000, 4'b0011, 1'b0, 1'b0, 8'd0);
    vecs[5] = mk(1'b0, 4'b0000, 4'b0111, 1'b0, 1'b0, 8'd0);
    vecs[6] = mk(1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0, 8'd0);
    vecs[7] = mk(1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0, 8'd0);
    vecs[8] = mk(1'b1, 4'b0000, 4'b1111, 1'b1, 1'b0, 8'd1);
    vecs[9] = mk(1'b0, 4'b0011, 4'b1111, 1'b1, 1'b0, 8'd2);
`else
    vecs[3] = mk(1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0, 8'd0);
    vecs[4] = mk(1'b1, 4'b0000, 4'b1111, 1'b1, 1'b0, 8'd1);
    vecs[5] = mk(1'b0, 4'b0011, 4'b1111, 1'b1, 1'b0, 8'd2);
    vecs[6] = mk(1'b0, 4'b0011, 4'b1111, 1'b1, 1'b0, 8'd3);
    vecs[7] = mk(1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0, 8'd4);
    vecs[8] = mk(1'b0, 4'b0011, 4'b1111, 1'b1, 1'b0, 8'd5);
    vecs[9] = mk(1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0, 8'd6);
`endif

    #3 rst = 1'b0;
    #1;
    chk("rst_a_core_rst_n", a_core_rst_n, 0);
    chk("rst_a_running", a_running, 0);
    chk("rst_a_done", a_done, 0);
    chk("rst_a_cnt", a_cnt, 0);
    chk("rst_b_state", b_state, 0);
    chk("rst_b_timeout", b_timeout, 0);
    repeat (2) tick();
    @(negedge clk) rst = 1'b1;
    tick();
    chk("idle_b_state", b_state, 0);
    chk("idle_b_core_rst_n", b_core_rst_n, 0);

    // table: start, ignored start in RESET/RUN, halted ignored before RUN, release pattern
    for (int i = 0; i < 10; i++) begin
      b_start  = vecs[i].start;
      b_halted = vecs[i].halted;
      tick();
      chk($sformatf("vec%0d_core_rst_n", i), b_core_rst_n, vecs[i].exp_rst_n);
      chk($sformatf("vec%0d_running", i), b_running, vecs[i].exp_run);
      chk($sformatf("vec%0d_done", i), b_done, vecs[i].exp_done);
      chk($sformatf("vec%0d_cnt", i), b_cnt, vecs[i].exp_cnt);
    end
    b_start = 1'b0;

    // cores 0/1 halt at count 10, cores 2/3 at 37; run ends only on the second
    for (int k = int'(vecs[9].exp_cnt); k <= 37; k++) begin
      b_halted = ((k >= 10) ? 4'b0011 : 4'b0000) | ((k >= 37) ? 4'b1100 : 4'b0000);
      tick();
      if (k < 37) begin
        chk("halt_partial_running", b_running, 1);
        chk("halt_partial_cnt", b_cnt, k + 1);
      end else begin
        chk("halt_done", b_done, 1);
        chk("halt_timeout", b_timeout, 0);
        chk("halt_cnt", b_cnt, 38);
        chk("halt_running", b_running, 0);
        chk("halt_core_rst_n", b_core_rst_n, 0);
      end
    end
    b_halted = 4'b1111;
    repeat (3) tick();
    chk("done_sticky", b_done, 1);
    chk("done_cnt_frozen", b_cnt, 38);
    chk("done_core_rst_n", b_core_rst_n, 0);
    b_start = 1'b1;
    b_halted = 4'b0000;
    tick();
    b_start = 1'b0;
    chk("restart_done_clr", b_done, 0);
    chk("restart_cnt_clr", b_cnt, 0);
    chk("restart_state", b_state, 1);

    // halt coincident with budget expiry: halt wins
    n = 0;
    while (b_running !== 1'b1 && n < 20) begin tick(); n++; end
    chk("coin_run_latency", n, RUN_LAT_B);
    chk("coin_cnt_start", b_cnt, 0);
    for (int k = 0; k < 50; k++) begin
      b_halted = (k == 49) ? 4'b1111 : 4'b0000;
      tick();
      if (k < 49) begin
        chk("coin_running", b_running, 1);
      end else begin
        chk("coin_done", b_done, 1);
        chk("coin_timeout", b_timeout, 0);
        chk("coin_cnt", b_cnt, 50);
      end
    end
    b_halted = 4'b0000;

    // dut_a: budget timeout, never halts
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("a_start_state", a_state, 1);
    tick();
    chk("a_hold_e1", a_core_rst_n, 0);
    tick();
    chk("a_hold_e2", a_core_rst_n, 0);
    tick();
    chk("a_release_e3", a_core_rst_n, 1);
    n = 3;
    while (a_running !== 1'b1 && n < 20) begin tick(); n++; end
    chk("a_run_latency", n, RUN_LAT_A);
    m = 0;
    while (a_done !== 1'b1 && m < 400) begin tick(); m++; end
    chk("a_done_latency", m, 200);
    chk("a_timeout", a_timeout, 1);
    chk("a_cnt_final", a_cnt, 200);
    chk("a_running_off", a_running, 0);
    chk("a_core_rst_n_done", a_core_rst_n, 0);

    // restart from DONE then reset mid-run at count 20
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("a_restart_done", a_done, 0);
    chk("a_restart_timeout", a_timeout, 0);
    chk("a_restart_cnt", a_cnt, 0);
    n = 0;
    while (!(a_running === 1'b1 && a_cnt == 32'd20) && n < 100) begin tick(); n++; end
    chk("a_reach_cnt20", a_cnt, 20);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_a_state", a_state, 0);
    chk("mid_rst_a_running", a_running, 0);
    chk("mid_rst_a_cnt", a_cnt, 0);
    chk("mid_rst_a_core_rst_n", a_core_rst_n, 0);
    chk("mid_rst_b_done", b_done, 0);
    chk("mid_rst_b_cnt", b_cnt, 0);
    @(negedge clk) rst = 1'b1;
    tick();
    chk("post_rst_idle", a_state, 0);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    n = 0;
    while (a_running !== 1'b1 && n < 20) begin tick(); n++; end
    chk("rerun_latency", n, RUN_LAT_A);
    chk("rerun_cnt0", a_cnt, 0);
    m = 0;
    while (a_done !== 1'b1 && m < 400) begin tick(); m++; end
    chk("rerun_cnt_final", a_cnt, 200);
    chk("rerun_timeout", a_timeout, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Parametrised run controller for the multi-core CPU build. It sequences per-core reset release, counts executed cycles, and ends a run when every core signals halt or when a cycle budget expires. It sits between the top-level clock/reset and the `cpu` instances, and it replaces fixed-delay reset and fixed-duration run control with synthesizable, observable run status.

## Interface

Parameters:
- `NUM_CORES`, 1: number of CPU cores controlled.
- `RST_HOLD`, 2: cycles core resets stay asserted after a start; must be ≥ 1.
- `RUN_CYCLES`, 200: cycle budget per run; 0 disables timeout.
- `CNT_W`, 32: width of `cycle_count`; `RUN_CYCLES` < 2^`CNT_W`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request pulse; sampled only in IDLE or DONE.
- `halted`  in  `NUM_CORES`  per-core halt status, synchronous to `clk`, level.
- `core_rst_n`  out  `NUM_CORES`  per-core active-low reset, registered.
- `running`  out  1  high while in RUN.
- `done`  out  1  run finished; sticky until next accepted `start`.
- `timeout`  out  1  run ended by budget expiry; valid when `done`=1.
- `cycle_count`  out  `CNT_W`  cycles spent in RUN, current or final.

## Operation

- States: IDLE, RESET, RELEASE (present only with stagger enabled), RUN, DONE.
- IDLE: `core_rst_n`=0. If `start`=1, go to RESET and load the hold counter.
- RESET: `core_rst_n`=0 for exactly `RST_HOLD` cycles. Then:
  - with stagger: go to RELEASE;
  - without stagger: set all `core_rst_n` bits to 1 and go to RUN.
- RELEASE: one core is released per cycle in index order, 0 first. After core `NUM_CORES`-1 is released, go to RUN. Released bits stay 1.
- RUN: `running`=1. `cycle_count` is cleared on entry and increments by 1 each cycle in RUN.
  - If all `halted` bits = 1: go to DONE with `timeout`=0.
  - Else if `RUN_CYCLES`≠0 and `cycle_count`==`RUN_CYCLES`-1: go to DONE with `timeout`=1.
- Simultaneous halt and budget expiry: halt wins, `timeout`=0.
- DONE:
  - `done`=1 and `core_rst_n`=0, so all cores are held in reset.
  - `cycle_count` is frozen at its final value.
  - `start`=1 clears `done`, `timeout` and `cycle_count`, then goes to RESET.
- `start` in RESET, RELEASE or RUN is ignored. No queueing.
- `halted` is ignored outside RUN. A core is never considered halted before release.
- `cycle_count` never wraps. Budget expiry or the `CNT_W` limit ends the run first. At all-ones with `RUN_CYCLES`=0, it holds and the run continues.

## Timing

- Reset (`rst`=0), asynchronous: state=IDLE, `core_rst_n`=0, `running`=0, `done`=0, `timeout`=0, `cycle_count`=0.
- Reset assertion mid-run aborts immediately to these values. Deassertion is honoured on the next rising edge.
- `start` sampled high at edge E0. Cores are in reset for edges E1..E`RST_HOLD`.
- Stagger: `core_rst_n[i]` rises after edge E(`RST_HOLD`+1+i). `running` rises after edge E(`RST_HOLD`+`NUM_CORES`+1).
- No stagger: all `core_rst_n` bits and `running` rise together after edge E(`RST_HOLD`+1).
- Halt observed at edge Eh: after Eh, `running`=0, `done`=1, `core_rst_n`=0. `cycle_count` includes the cycle at Eh.
- Timeout: `done` rises exactly `RUN_CYCLES` cycles after `running` rises, with final `cycle_count`=`RUN_CYCLES`.
- All outputs are registered. No combinational input-to-output paths.

## Configuration

- `RUN_CTRL_STAGGER_EN` defined: the RELEASE state exists and cores come out of reset one per cycle, limiting inrush and making release order deterministic.
- Not defined: the RELEASE state is compiled out and all cores release on the same edge. All other behaviour is identical.

## Test plan

- `NUM_CORES`=1, `RST_HOLD`=2, `RUN_CYCLES`=200, never halt:
  - `start` -> `core_rst_n` low 2 cycles, `running` for 200 cycles;
  - `done`=1, `timeout`=1, `cycle_count`=200.
- `NUM_CORES`=4, stagger on:
  - `start` -> `core_rst_n` = 0001, 0011, 0111, 1111 on 4 consecutive cycles;
  - `running` asserts the following cycle.
- `NUM_CORES`=2, halt both cores at RUN cycle 37 (cores halt individually at 10 and 37):
  - `done`=1, `timeout`=0, `cycle_count`=38;
  - earlier single-core halt does not end the run.
- Halt coincident with budget (`RUN_CYCLES`=50, both halt in the cycle `cycle_count`=49):
  - `timeout`=0, `cycle_count`=50.
- `rst`=0 pulse mid-RUN at `cycle_count`=20:
  - all outputs return to reset values asynchronously, state IDLE;
  - the next `start` performs a full sequence with `cycle_count` from 0.
- `start` pulsed during RESET and RUN is ignored. In DONE, `start` clears `done`, `timeout` and `cycle_count` on the next edge and restarts the sequence.
